// File: rtl/clock_stepper_pkg.sv
// clock_stepper_pkg: shared mode/state types and index-width helper for the clock stepper
package clock_stepper_pkg;
  typedef enum logic [1:0] {HALT, RUN, STEP, BURST} stepper_mode_t;
  typedef enum logic [1:0] {IDLE_S, RUN_S, BURST_S, BREAK_S} state_t;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/clock_stepper_bp_compare.sv
// bp_compare: combinational breakpoint matcher where the lowest matching index wins
module bp_compare
  import clock_stepper_pkg::*;
#(
  parameter int NUM_BP     = 2,
  parameter int ADDR_WIDTH = 16
) (
  input  logic [ADDR_WIDTH-1:0]        pc,
  input  logic [NUM_BP*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_BP-1:0]            en,
  output logic                         match,
  output logic [idx_width(NUM_BP)-1:0] index
);
  localparam int IW = idx_width(NUM_BP);
  always_comb begin
    match = 1'b0;
    index = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (en[i] && pc == addr[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        match = 1'b1;
        index = IW'(i);
      end
    end
  end
endmodule

// File: rtl/clock_stepper.sv
// clock_stepper: core clock-enable generator with halt/run/step/burst modes, breakpoints and a retired-step counter
module clock_stepper
  import clock_stepper_pkg::*;
#(
  parameter int DIV_WIDTH   = 16,
  parameter int BURST_WIDTH = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int NUM_BP      = 2,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   mode,
  input  logic                         step,
  input  logic [DIV_WIDTH-1:0]         div,
  input  logic [BURST_WIDTH-1:0]       burst_len,
  input  logic [ADDR_WIDTH-1:0]        pc,
  input  logic [NUM_BP*ADDR_WIDTH-1:0] bp_addr,
  input  logic [NUM_BP-1:0]            bp_en,
  input  logic                         bp_clear,
  output logic                         core_ce,
  output logic                         running,
  output logic                         bp_hit,
  output logic [idx_width(NUM_BP)-1:0] bp_index,
  output logic [CNT_WIDTH-1:0]         step_count
);
  localparam int IW = idx_width(NUM_BP);
  stepper_mode_t m;
  state_t state, state_d;
  logic [DIV_WIDTH-1:0] presc, presc_d;
  logic [BURST_WIDTH-1:0] rem, rem_d;
  logic [IW-1:0] idx_d, hit_idx;
  logic step_q, trig, match, tick, ce_d, active, stays;
  assign m = stepper_mode_t'(mode);
  assign trig = step & ~step_q;
  assign active = state == RUN_S || state == BURST_S;
  assign tick = active && presc == '0;
  assign stays = state_d == RUN_S || state_d == BURST_S;
  assign presc_d = (active && stays) ? (tick ? div : presc - DIV_WIDTH'(1)) : '0;
  bp_compare #(.NUM_BP(NUM_BP), .ADDR_WIDTH(ADDR_WIDTH)) u_bp (
    .pc(pc), .addr(bp_addr), .en(bp_en), .match(match), .index(hit_idx)
  );
  always_comb begin
    state_d = state;
    ce_d = 1'b0;
    rem_d = rem;
    idx_d = bp_index;
    case (state)
      IDLE_S:
        if (m == RUN) state_d = RUN_S;
        else if (m == STEP && trig) ce_d = 1'b1;
        else if (m == BURST && trig && burst_len != '0) begin
          state_d = BURST_S;
          rem_d = burst_len;
        end
      RUN_S:
        if (m != RUN) state_d = IDLE_S;
        else if (tick && match) begin
          state_d = BREAK_S;
          idx_d = hit_idx;
        end
        else ce_d = tick;
      BURST_S:
        if (m != BURST) begin
          state_d = IDLE_S;
          rem_d = '0;
        end
        else if (tick && match) begin
          state_d = BREAK_S;
          idx_d = hit_idx;
          rem_d = '0;
        end
        else if (tick) begin
          ce_d = 1'b1;
          rem_d = rem - BURST_WIDTH'(1);
          state_d = rem == BURST_WIDTH'(1) ? IDLE_S : BURST_S;
        end
      BREAK_S:
        if (m == HALT) state_d = IDLE_S;
        else if (m == STEP && trig) begin
          ce_d = 1'b1;
          state_d = IDLE_S;
        end
        else if (bp_clear) state_d = IDLE_S;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE_S;
      presc <= '0;
      rem <= '0;
      step_q <= 1'b0;
      core_ce <= 1'b0;
      running <= 1'b0;
      bp_hit <= 1'b0;
      bp_index <= '0;
      step_count <= '0;
    end else begin
      state <= state_d;
      presc <= presc_d;
      rem <= rem_d;
      step_q <= step;
      core_ce <= ce_d;
      running <= stays;
      bp_hit <= state_d == BREAK_S;
      bp_index <= idx_d;
      step_count <= step_count + CNT_WIDTH'(core_ce);
    end
  end
endmodule
